value_sequencer: RTL and testbench
==================================

VALUE_SEQUENCER -- requirements
Module: value_sequencer

Interface
REQ-001 Parameter DEB_CYCLES, default 16: consecutive stable cycles required to accept a button level change; legal range 2..65535.
REQ-002 Parameter AUTO_DIV, default 8: clk cycles per automatic step in AUTO state; legal range 2..65535.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 btn_up  in  1  raw, asynchronous, bouncy push-button; high = pressed.
REQ-006 btn_down  in  1  raw, asynchronous, bouncy push-button; high = pressed.
REQ-007 auto_en  in  1  level; 1 selects automatic stepping.
REQ-008 A  out  1  registered value bit 2 (MSB), feeding the segment decoders.
REQ-009 B  out  1  registered value bit 1.
REQ-010 C  out  1  registered value bit 0 (LSB).
REQ-011 step  out  1  registered one-cycle pulse, high in the cycle {A,B,C} first shows a new value.

Function
REQ-012 Each of btn_up and btn_down SHALL pass through its own 2-flop synchronizer before any other use.
REQ-013 Per button: debounce counter cleared whenever synchronized input equals debounced level; incremented otherwise; debounced level toggles on the edge where DEB_CYCLES consecutive differing samples are reached.
REQ-014 Differing runs shorter than DEB_CYCLES SHALL leave debounced level unchanged (glitch rejected).
REQ-015 Press event = debounced level 0->1 transition; release (1->0) SHALL generate no event.
REQ-016 FSM states MANUAL and AUTO; MANUAL->AUTO on the edge where auto_en=1; AUTO->MANUAL on the edge where auto_en=0.
REQ-017 In MANUAL: up event only -> value+1; down event only -> value-1; both events in the same cycle -> no change, step stays 0.
REQ-018 Arithmetic modulo 8: 7+1 wraps to 0; 0-1 wraps to 7.
REQ-019 Latency in MANUAL: with raw button clean and held, {A,B,C} and step update on the (DEB_CYCLES+2)th rising edge after the first edge sampling the raw input high.
REQ-020 In AUTO: divider counts 0..AUTO_DIV-1; on the terminal-count edge value+1 and step pulses; step thus repeats every AUTO_DIV cycles.
REQ-021 Divider SHALL be 0 while in MANUAL; first AUTO step occurs AUTO_DIV edges after entering AUTO.
REQ-022 In AUTO, press events SHALL be ignored (no value change); debouncers keep running so levels stay current.
REQ-023 step SHALL be 0 in every cycle where the value does not change.

Reset
REQ-024 rst=1 at a rising edge SHALL set: value 3'b000 (A=B=C=0), step 0, FSM MANUAL, divider 0, synchronizers 0, debounced levels 0, debounce counters 0.
REQ-025 rst SHALL take priority over every other input, including mid-debounce and mid-divide.
REQ-026 A button held high across reset release SHALL be accepted as a press after the normal debounce latency.

Verification (DEB_CYCLES=4, AUTO_DIV=8)
REQ-027 rst, then btn_up clean high held -> value 0->1 on edge 6 after first sample, step high exactly 1 cycle; hold 20 more cycles -> no further change.
REQ-028 Value 7, up press -> 0; then down press -> 7; step pulses once per press.
REQ-029 btn_up high pulses of 1, 2, 3 cycles, separated by 5 low cycles -> value stays 0, step never asserted.
REQ-030 btn_up and btn_down rise on the same edge, clean -> debounced events coincide, value unchanged, step 0.
REQ-031 auto_en=1 from value 5 -> value 6,7,0 at edges 8,16,24 after entry; btn_down press during AUTO -> ignored; auto_en=0 -> stepping stops, divider 0.
REQ-032 rst asserted 2 cycles into a debounce run with btn_up held -> all outputs 0 next edge; after release, value 1 after 6 further edges.

Source files
------------

// File: rtl/value_sequencer_if.sv
// Bundle of the button/mode inputs and the 3-bit value/step outputs of the sequencer.
interface value_sequencer_if;
  logic btn_up;
  logic btn_down;
  logic auto_en;
  logic A;
  logic B;
  logic C;
  logic step;

  modport master (
    output btn_up,
    output btn_down,
    output auto_en,
    input  A,
    input  B,
    input  C,
    input  step
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  auto_en,
    output A,
    output B,
    output C,
    output step
  );
endinterface

// File: rtl/value_sequencer.sv
// 3-bit modulo-8 counter stepped by debounced up/down buttons (MANUAL) or a clock divider (AUTO).
module value_sequencer #(
  parameter int DEB_CYCLES = 16,
  parameter int AUTO_DIV   = 8
) (
  input  logic             clk,
  input  logic             rst,
  value_sequencer_if.slave bus
);

  localparam int CNT_W = 16;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } state_t;

  function automatic logic [2:0] inc_mod8(input logic [2:0] v);
    return v + 3'd1;
  endfunction

  function automatic logic [2:0] dec_mod8(input logic [2:0] v);
    return v - 3'd1;
  endfunction

  // Button index 0 = up, 1 = down.
  logic [1:0]       raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       level;
  logic [CNT_W-1:0] deb_cnt [2];
  logic [1:0]       accept;
  logic [1:0]       press;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] div_next;
  logic [2:0]       value;
  logic [2:0]       value_next;
  logic             step_q;
  logic             step_next;

  assign raw = {bus.btn_down, bus.btn_up};

  // Stage p0/p1: two-flop synchronizers ahead of everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Accept is combinational so the value can move on the same edge the level toggles.
  always_comb begin
    accept = 2'b00;
    press  = 2'b00;
    for (int b = 0; b < 2; b++) begin
      accept[b] = (sync_p1[b] != level[b]) &&
                  (deb_cnt[b] == CNT_W'(DEB_CYCLES - 1));
      press[b]  = accept[b] & ~level[b];
    end
  end

  // Debounce stage: counter runs only while the synchronized sample disagrees with the level
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        deb_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_p1[b] == level[b]) begin
          deb_cnt[b] <= '0;
        end else if (accept[b]) begin
          deb_cnt[b] <= '0;
          level[b]   <= ~level[b];
        end else begin
          deb_cnt[b] <= deb_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    div_next   = div;
    value_next = value;
    step_next  = 1'b0;
    case (state)
      MANUAL: begin
        div_next = '0;
        if (press == 2'b01) begin
          value_next = inc_mod8(value);
          step_next  = 1'b1;
        end else if (press == 2'b10) begin
          value_next = dec_mod8(value);
          step_next  = 1'b1;
        end
        if (bus.auto_en) begin
          state_next = AUTO;
        end
      end
      AUTO: begin
        // Press events are deliberately ignored here; the debouncers still track the buttons.
        if (!bus.auto_en) begin
          state_next = MANUAL;
          div_next   = '0;
        end else if (div == CNT_W'(AUTO_DIV - 1)) begin
          div_next   = '0;
          value_next = inc_mod8(value);
          step_next  = 1'b1;
        end else begin
          div_next = div + CNT_W'(1);
        end
      end
      default: begin
        state_next = MANUAL;
        div_next   = '0;
      end
    endcase
  end

  // Output stage: value and step registered together so step marks the first cycle of a new value
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MANUAL;
      div    <= '0;
      value  <= 3'b000;
      step_q <= 1'b0;
    end else begin
      state  <= state_next;
      div    <= div_next;
      value  <= value_next;
      step_q <= step_next;
    end
  end

  assign bus.A    = value[2];
  assign bus.B    = value[1];
  assign bus.C    = value[0];
  assign bus.step = step_q;

endmodule

// File: tb/tb_value_sequencer.sv
// Bench for value_sequencer: directed table, multi-cycle corner sequences, and randomized run against a model.
module tb_value_sequencer;

  localparam int DEB = 4;
  localparam int ADIV = 8;

  logic clk;
  logic rst;
  value_sequencer_if bus ();

  value_sequencer #(.DEB_CYCLES(DEB), .AUTO_DIV(ADIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit up_pipe[$];
  bit dn_pipe[$];
  bit up_run[$];
  bit dn_run[$];
  bit m_lvl_up, m_lvl_dn;
  int m_val;
  bit m_step;
  bit m_auto;
  int m_since;

  task automatic model_reset();
    up_pipe = '{0, 0};
    dn_pipe = '{0, 0};
    up_run.delete();
    dn_run.delete();
    m_lvl_up = 0;
    m_lvl_dn = 0;
    m_val = 0;
    m_step = 0;
    m_auto = 0;
    m_since = 0;
  endtask

  // A press is accepted once DEB consecutive synchronized samples disagree with the current level.
  task automatic debounce(input bit raw, inout bit pipe[$], inout bit run[$],
                          inout bit lvl, output bit ev);
    bit s;
    ev = 0;
    s = pipe.pop_front();
    pipe.push_back(raw);
    if (s == lvl) begin
      run.delete();
    end else begin
      run.push_back(s);
      if (run.size() >= DEB) begin
        lvl = ~lvl;
        ev = lvl;
        run.delete();
      end
    end
  endtask

  task automatic model_step(input bit u, input bit d, input bit a, input bit r);
    bit eu, ed;
    if (r) begin
      model_reset();
      return;
    end
    debounce(u, up_pipe, up_run, m_lvl_up, eu);
    debounce(d, dn_pipe, dn_run, m_lvl_dn, ed);
    m_step = 0;
    if (!m_auto) begin
      if (eu && !ed) begin
        m_val = (m_val + 1) % 8;
        m_step = 1;
      end else if (ed && !eu) begin
        m_val = (m_val + 7) % 8;
        m_step = 1;
      end
      if (a) begin
        m_auto = 1;
        m_since = 0;
      end
    end else if (!a) begin
      m_auto = 0;
      m_since = 0;
    end else begin
      m_since++;
      if (m_since % ADIV == 0) begin
        m_val = (m_val + 1) % 8;
        m_step = 1;
      end
    end
  endtask

  task automatic tick(input bit u, input bit d, input bit a, input bit r);
    bus.btn_up   = u;
    bus.btn_down = d;
    bus.auto_en  = a;
    rst          = r;
    @(posedge clk);
    model_step(u, d, a, r);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_val();
    return {29'd0, bus.A, bus.B, bus.C};
  endfunction

  task automatic check_model(input string tag);
    check({tag, " value"}, dut_val(), m_val);
    check({tag, " step"}, int'(bus.step), int'(m_step));
  endtask

  task automatic press(input bit is_up);
    repeat (DEB + 2) tick(is_up, !is_up, 0, 0);
    repeat (8) tick(0, 0, 0, 0);
  endtask

  typedef struct {
    bit up;
    bit dn;
    bit au;
    int cycles;
    int exp_val;
    bit exp_step;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit lu, ld, la, gu, gd, rr;
    model_reset();
    bus.btn_up = 0;
    bus.btn_down = 0;
    bus.auto_en = 0;
    rst = 1;

    tbl.push_back('{1, 0, 0, 5, 0, 0});   // first press, before debounce completes
    tbl.push_back('{1, 0, 0, 1, 1, 1});   // edge 6: value 1 with step
    tbl.push_back('{1, 0, 0, 1, 1, 0});   // step lasts one cycle
    tbl.push_back('{1, 0, 0, 20, 1, 0});  // held: no repeat
    tbl.push_back('{0, 0, 0, 3, 1, 0});   // release gives no event
    tbl.push_back('{0, 0, 0, 5, 1, 0});
    tbl.push_back('{0, 1, 0, 5, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 1});   // down press 1 -> 0
    tbl.push_back('{0, 0, 0, 8, 0, 0});
    tbl.push_back('{0, 1, 0, 6, 7, 1});   // 0 - 1 wraps to 7
    tbl.push_back('{0, 0, 0, 8, 7, 0});
    tbl.push_back('{1, 1, 0, 6, 7, 0});   // simultaneous presses cancel
    tbl.push_back('{0, 0, 0, 8, 7, 0});
    tbl.push_back('{1, 0, 0, 6, 0, 1});   // 7 + 1 wraps to 0
    tbl.push_back('{0, 0, 0, 8, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0});   // glitch widths 1, 2, 3
    tbl.push_back('{0, 0, 0, 5, 0, 0});
    tbl.push_back('{1, 0, 0, 2, 0, 0});
    tbl.push_back('{0, 0, 0, 5, 0, 0});
    tbl.push_back('{1, 0, 0, 3, 0, 0});
    tbl.push_back('{0, 0, 0, 5, 0, 0});

    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("reset value", dut_val(), 0);
    check("reset step", int'(bus.step), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        tick(tbl[i].up, tbl[i].dn, tbl[i].au, 0);
        check_model("table model");
      end
      check($sformatf("table[%0d] value", i), dut_val(), tbl[i].exp_val);
      check($sformatf("table[%0d] step", i), int'(bus.step), int'(tbl[i].exp_step));
    end

    // Reach value 5, then run AUTO with a down press that must be ignored
    repeat (5) press(1);
    check("five presses value", dut_val(), 5);
    tick(0, 0, 1, 0);
    check("auto entry value", dut_val(), 5);
    check("auto entry step", int'(bus.step), 0);
    for (int i = 1; i <= 24; i++) begin
      tick(0, (i >= 2 && i < 12), 1, 0);
      check($sformatf("auto %0d value", i), dut_val(), (5 + i / ADIV) % 8);
      check($sformatf("auto %0d step", i), int'(bus.step), int'(i % ADIV == 0));
    end
    tick(0, 0, 0, 0);
    check("auto exit value", dut_val(), 0);
    check("auto exit step", int'(bus.step), 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      check("manual hold value", dut_val(), 0);
      check("manual hold step", int'(bus.step), 0);
    end
    // Divider must restart from zero on re-entry
    tick(0, 0, 1, 0);
    for (int i = 1; i <= ADIV; i++) begin
      tick(0, 0, 1, 0);
      check($sformatf("reentry %0d value", i), dut_val(), int'(i == ADIV));
      check($sformatf("reentry %0d step", i), int'(bus.step), int'(i == ADIV));
    end
    tick(0, 0, 0, 0);
    check("reentry exit value", dut_val(), 1);

    // Reset mid-debounce with btn_up held through release
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 1);
    check("mid-debounce reset value", dut_val(), 0);
    check("mid-debounce reset step", int'(bus.step), 0);
    for (int i = 1; i <= DEB + 2; i++) begin
      tick(1, 0, 0, 0);
      check($sformatf("held through reset %0d value", i), dut_val(), int'(i == DEB + 2));
      check($sformatf("held through reset %0d step", i), int'(bus.step), int'(i == DEB + 2));
    end
    tick(0, 0, 0, 0);

    // Randomized run: slow button levels with short glitches, rare mode changes and resets
    lu = 0; ld = 0; la = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 29) == 0) lu = ~lu;
      if ($urandom_range(0, 29) == 0) ld = ~ld;
      if ($urandom_range(0, 199) == 0) la = ~la;
      gu = ($urandom_range(0, 14) == 0);
      gd = ($urandom_range(0, 14) == 0);
      rr = ($urandom_range(0, 599) == 0);
      tick(lu ^ gu, ld ^ gd, la, rr);
      check_model("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
